// File: rtl/ahb_arb_pkg.sv
// Shared AHB encodings and burst-length decode for the output-stage arbiter.
package ahb_arb_pkg;

  localparam int NUM_PORTS = 3;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  // Beats still owed after the NONSEQ beat; undefined-length INCR owes none.
  function automatic logic [3:0] burst_len(input logic [2:0] hburst);
    logic [3:0] len;
    case (hburst_e'(hburst))
      HBURST_WRAP4,  HBURST_INCR4:  len = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  len = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: len = 4'd15;
      default:                      len = 4'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ahb_arb_beat_cnt.sv
// Tracks remaining beats of the owner's fixed-length burst and raises hold
// while the grant must not move (lock, BUSY, or beats still outstanding).
module ahb_arb_beat_cnt
  import ahb_arb_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       HREADYM,
  input  logic       HSELM,
  input  logic [1:0] HTRANSM,
  input  logic [2:0] HBURSTM,
  input  logic       HMASTLOCKM,
  output logic       hold_o
);

  logic [3:0] beat_cnt_q;
  logic [3:0] beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (HREADYM) begin
      if (!HSELM || (HTRANSM == HTRANS_IDLE)) begin
        beat_cnt_d = 4'd0;
      end else if (HTRANSM == HTRANS_NONSEQ) begin
        beat_cnt_d = burst_len(HBURSTM);
      end else if ((HTRANSM == HTRANS_SEQ) && (beat_cnt_q != 4'd0)) begin
        beat_cnt_d = beat_cnt_q - 4'd1;
      end
    end
  end

  // Judged on the count after the beat now being accepted, so the grant sticks
  // from the NONSEQ beat and is released on the edge that takes the last beat.
  assign hold_o = HMASTLOCKM
                | (HSELM && (HTRANSM == HTRANS_BUSY))
                | (beat_cnt_d != 4'd0);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      beat_cnt_q <= 4'd0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: rtl/ahb_out_stg_arb.sv
// AHB output-stage arbiter: registered grant of one of three input stages.
// Define AHB_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority 0>1>2.
module ahb_out_stg_arb
  import ahb_arb_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       req_port0,
  input  logic       req_port1,
  input  logic       req_port2,
  input  logic       HREADYM,
  input  logic       HSELM,
  input  logic [1:0] HTRANSM,
  input  logic [2:0] HBURSTM,
  input  logic       HMASTLOCKM,
  output logic [2:0] addr_in_port,
  output logic       no_port
);

  logic [NUM_PORTS-1:0] req_vec;
  logic                 any_req;
  logic                 hold;
  logic                 arb_point;
  logic [1:0]           winner;
  logic [1:0]           port_q, port_d;
  logic                 no_port_q, no_port_d;

  assign req_vec   = {req_port2, req_port1, req_port0};
  assign any_req   = |req_vec;
  assign arb_point = HREADYM && !hold;

  ahb_arb_beat_cnt u_beat_cnt (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HREADYM    (HREADYM),
    .HSELM      (HSELM),
    .HTRANSM    (HTRANSM),
    .HBURSTM    (HBURSTM),
    .HMASTLOCKM (HMASTLOCKM),
    .hold_o     (hold)
  );

`ifdef AHB_ARB_ROUND_ROBIN_EN
  logic [1:0] last_q, last_d;
  logic [1:0] rr_cand;
  logic       rr_found;

  // Walk 0->1->2->0 starting just after the last granted port.
  always_comb begin
    winner   = 2'd0;
    rr_found = 1'b0;
    rr_cand  = last_q;
    for (int k = 0; k < NUM_PORTS; k++) begin
      rr_cand = (rr_cand == 2'(NUM_PORTS - 1)) ? 2'd0 : rr_cand + 2'd1;
      if (req_vec[rr_cand] && !rr_found) begin
        winner   = rr_cand;
        rr_found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    if (req_vec[0]) begin
      winner = 2'd0;
    end else if (req_vec[1]) begin
      winner = 2'd1;
    end else begin
      winner = 2'd2;
    end
  end
`endif

  // With no request the port index is kept so the data-phase mux stays put.
  always_comb begin
    port_d    = port_q;
    no_port_d = no_port_q;
`ifdef AHB_ARB_ROUND_ROBIN_EN
    last_d    = last_q;
`endif
    if (arb_point) begin
      if (any_req) begin
        port_d    = winner;
        no_port_d = 1'b0;
`ifdef AHB_ARB_ROUND_ROBIN_EN
        last_d    = winner;
`endif
      end else begin
        no_port_d = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      port_q    <= 2'd0;
      no_port_q <= 1'b1;
`ifdef AHB_ARB_ROUND_ROBIN_EN
      last_q    <= 2'd2;
`endif
    end else begin
      port_q    <= port_d;
      no_port_q <= no_port_d;
`ifdef AHB_ARB_ROUND_ROBIN_EN
      last_q    <= last_d;
`endif
    end
  end

  assign addr_in_port = {1'b0, port_q};
  assign no_port      = no_port_q;

endmodule

// File: tb/tb_ahb_out_stg_arb.sv
// Scoreboard bench for ahb_out_stg_arb: directed scenarios then random traffic,
// expectations from a beat-counting reference model of the arbitration rules.
module tb_ahb_out_stg_arb;

  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NONSEQ = 2'd2, T_SEQ = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_INCR4 = 3'd3,
                         B_INCR8 = 3'd5, B_INCR16 = 3'd7;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       req_port0, req_port1, req_port2;
  logic       HREADYM, HSELM, HMASTLOCKM;
  logic [1:0] HTRANSM;
  logic [2:0] HBURSTM;
  logic [2:0] addr_in_port;
  logic       no_port;

  always #5 HCLK = ~HCLK;

  ahb_out_stg_arb dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .req_port0    (req_port0),
    .req_port1    (req_port1),
    .req_port2    (req_port2),
    .HREADYM      (HREADYM),
    .HSELM        (HSELM),
    .HTRANSM      (HTRANSM),
    .HBURSTM      (HBURSTM),
    .HMASTLOCKM   (HMASTLOCKM),
    .addr_in_port (addr_in_port),
    .no_port      (no_port)
  );

  typedef struct {
    int    port;
    bit    np;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: owner, idle flag, last grant and beats the owner still owes.
  int m_port, m_last, m_left;
  bit m_np;
  int len_tab[8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  task automatic check(input string name, input int port, input bit np);
    n_tests++;
    if (addr_in_port !== 3'(port) || no_port !== np) begin
      n_fail++;
      $display("FAIL %s: got addr_in_port=%0d no_port=%0b, expected addr_in_port=%0d no_port=%0b",
               name, addr_in_port, no_port, port, np);
    end else begin
      $display("[TB] ok %s: addr_in_port=%0d no_port=%0b", name, addr_in_port, no_port);
    end
  endtask

  task automatic model_reset();
    m_port = 0;
    m_np   = 1'b1;
    m_last = 2;
    m_left = 0;
  endtask

  task automatic model_edge(input string tag);
    int         nl;
    int         win;
    logic [2:0] rv;
    exp_t       e;
    rv  = {req_port2, req_port1, req_port0};
    win = -1;
    nl  = 0;
    if (!HRESETn) begin
      model_reset();
    end else if (HREADYM) begin
      if (!HSELM || HTRANSM == T_IDLE)  nl = 0;
      else if (HTRANSM == T_NONSEQ)     nl = len_tab[HBURSTM] - 1;
      else if (HTRANSM == T_SEQ)        nl = (m_left > 0) ? m_left - 1 : 0;
      else                              nl = m_left;
      if (!(HMASTLOCKM || (HSELM && HTRANSM == T_BUSY) || nl > 0)) begin
`ifdef AHB_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 3; k++)
          if (win < 0 && rv[(m_last + k) % 3]) win = (m_last + k) % 3;
`else
        for (int p = 0; p < 3; p++)
          if (win < 0 && rv[p]) win = p;
`endif
        if (win >= 0) begin
          m_port = win;
          m_np   = 1'b0;
          m_last = win;
        end else begin
          m_np = 1'b1;
        end
      end
      m_left = nl;
    end
    e.port = m_port;
    e.np   = m_np;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  // Called at posedge+3: drive one cycle, predict the next edge, advance.
  task automatic step(input string tag, input logic [2:0] req, input logic rdy,
                      input logic sel, input logic [1:0] tr, input logic [2:0] bu,
                      input logic lk);
    {req_port2, req_port1, req_port0} = req;
    HREADYM    = rdy;
    HSELM      = sel;
    HTRANSM    = tr;
    HBURSTM    = bu;
    HMASTLOCKM = lk;
    model_edge(tag);
    @(posedge HCLK);
    #3;
  endtask

  always begin
    @(posedge HCLK);
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check(mon_e.tag, mon_e.port, mon_e.np);
    end
  end

  initial begin
    HRESETn = 1'b0;
    {req_port2, req_port1, req_port0} = 3'b111;
    HREADYM = 1'b1; HSELM = 1'b0; HTRANSM = T_IDLE; HBURSTM = B_SINGLE; HMASTLOCKM = 1'b0;
    model_reset();
    repeat (2) @(posedge HCLK);
    #3;
    check("reset_state", 0, 1'b1);
    HRESETn = 1'b1;
    step("first_ap", 3'b111, 1, 0, T_IDLE, B_SINGLE, 0);

    for (int i = 0; i < 4; i++) step("all_req_single", 3'b111, 1, 1, T_NONSEQ, B_SINGLE, 0);

    step("burst_grant_p1", 3'b010, 1, 0, T_IDLE,   B_SINGLE, 0);
    step("burst_nonseq",   3'b011, 1, 1, T_NONSEQ, B_INCR4,  0);
    step("burst_seq1",     3'b011, 1, 1, T_SEQ,    B_INCR4,  0);
    step("burst_busy",     3'b011, 1, 1, T_BUSY,   B_INCR4,  0);
    step("burst_wait1",    3'b011, 0, 1, T_SEQ,    B_INCR4,  0);
    step("burst_wait2",    3'b011, 0, 1, T_SEQ,    B_INCR4,  0);
    step("burst_seq2",     3'b011, 1, 1, T_SEQ,    B_INCR4,  0);
    step("burst_seq3",     3'b011, 1, 1, T_SEQ,    B_INCR4,  0);
    step("burst_after",    3'b011, 1, 0, T_IDLE,   B_SINGLE, 0);

    step("incr_grant_p1",  3'b010, 1, 0, T_IDLE,   B_SINGLE, 0);
    step("incr_rearb",     3'b011, 1, 1, T_NONSEQ, B_INCR,   0);

    step("lock_grant_p2",  3'b100, 1, 0, T_IDLE,   B_SINGLE, 0);
    for (int i = 0; i < 3; i++) step("lock_held", 3'b111, 1, 1, T_NONSEQ, B_SINGLE, 1);
    step("lock_release",   3'b111, 1, 1, T_IDLE,   B_SINGLE, 0);

    step("i8_grant_p1",    3'b010, 1, 0, T_IDLE,   B_SINGLE, 0);
    step("i8_nonseq",      3'b111, 1, 1, T_NONSEQ, B_INCR8,  0);
    step("i8_seq1",        3'b111, 1, 1, T_SEQ,    B_INCR8,  0);
    step("i8_seq2",        3'b111, 1, 1, T_SEQ,    B_INCR8,  0);
    step("i8_idle_term",   3'b111, 1, 1, T_IDLE,   B_INCR8,  0);

    step("noreq_grant_p1", 3'b010, 1, 0, T_IDLE,   B_SINGLE, 0);
    step("noreq_drop",     3'b000, 1, 0, T_IDLE,   B_SINGLE, 0);
    step("noreq_stall",    3'b101, 0, 0, T_IDLE,   B_SINGLE, 0);
    step("noreq_again",    3'b000, 1, 0, T_IDLE,   B_SINGLE, 0);

    step("i16_grant_p1",   3'b010, 1, 0, T_IDLE,   B_SINGLE, 0);
    step("i16_nonseq",     3'b011, 1, 1, T_NONSEQ, B_INCR16, 0);
    step("i16_seq",        3'b011, 1, 1, T_SEQ,    B_INCR16, 0);
    HRESETn = 1'b0;
    #1;
    check("async_reset", 0, 1'b1);
    step("reset_held",     3'b011, 1, 1, T_SEQ,    B_INCR16, 0);
    HRESETn = 1'b1;
    step("post_reset_ap",  3'b011, 1, 0, T_IDLE,   B_SINGLE, 0);

    for (int i = 0; i < 400; i++) begin
      step("random",
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 6) == 0));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge HCLK);
    #3;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected responses left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
